dmux4_dispatcher: RTL
=====================

Name: dmux4_dispatcher

Overview:
- Sequencer for a 1-to-4 demux path: accepts one data item at a time from a single producer and delivers it to one of four consumer channels.
- Generates the 2-bit select for the demux and a one-hot per-channel valid.
- Two routing modes:
  - Addressed: destination comes from the item.
  - Round-robin: the block picks the destination and skips stalled channels.
- Sits between a single producer and four consumers.

Parameters:
- WIDTH, 8, data item width in bits.
- SKIP_LIMIT, 4, round-robin mode only: number of consecutive stalled cycles on the target channel before the block moves to the next channel (must be ≥1).
- CNT_W, 3, width of the internal stall counter (must hold SKIP_LIMIT).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has an item.
- in_data  input  WIDTH  item payload.
- in_dest  input  2  target channel (addressed mode only).
- mode  input  1  0 = addressed, 1 = round-robin; sampled at capture.
- in_ready  output  1  block can accept an item this cycle.
- out_data  output  WIDTH  buffered payload, common to all channels.
- out_valid  output  4  one-hot valid; bit i = channel i (a=0, b=1, c=2, d=3).
- out_ready  input  4  per-channel consumer ready.
- sel  output  2  current demux select; equals the index of the asserted out_valid bit.
- skipped  output  1  one-cycle pulse when round-robin abandons a stalled channel.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, out_valid=0, out_data=0, sel=0, round-robin pointer rr_ptr=0, stall counter=0, skipped=0, buffered mode bit=0. in_ready=0 while reset is high.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid=1: register in_data into out_data and register mode.
    - Register sel: in_dest if mode=0, rr_ptr if mode=1.
    - Clear stall counter and go to SEND.
  - SEND: in_ready=0; out_valid = one-hot(sel); out_data and sel held stable.
    - Transfer occurs in any cycle where out_ready[sel]=1. On transfer: go to IDLE; if buffered mode=1, rr_ptr <= sel+1 (mod 4); stall counter cleared.
    - No transfer, buffered mode=0: wait indefinitely; no skip, no counter advance.
    - No transfer, buffered mode=1: stall counter increments. When it reaches SKIP_LIMIT-1 and still no transfer:
      - sel <= sel+1 (mod 4) and counter cleared;
      - skipped pulses high for exactly the next cycle;
      - stay in SEND, with out_valid moving to the new channel the cycle after.
- Latency and throughput:
  - Item visible on out_valid one cycle after capture.
  - Maximum throughput is one item per 2 cycles: no IDLE/SEND overlap, and in_ready is never high in SEND.
- Boundary conditions:
  - out_ready bits of non-selected channels are ignored.
  - The round-robin pointer wraps 3→0.
  - A skip wraps sel 3→0.
  - A skip can cycle through all four channels repeatedly without limit.
  - Changing mode or in_dest during SEND has no effect; only the values captured in IDLE apply.
- Reset during SEND: the item is dropped, outputs return to reset values immediately (asynchronous), and rr_ptr returns to 0.
- Invariants: out_valid is never more than one-hot, and out_valid=0 whenever state is IDLE.

Test Plan:
- Reset, then addressed mode, in_data=0xA5, in_dest=2, out_ready=4'b0100 → capture cycle, next cycle out_valid=4'b0100, sel=2, out_data=0xA5; transfer, IDLE following cycle, in_ready=1.
- Round-robin, out_ready=4'hF, items 0x10,0x11,0x12,0x13,0x14 → delivered to channels 0,1,2,3,0 in order; one item per 2 cycles; skipped never pulses.
- Round-robin, SKIP_LIMIT=4, out_ready=4'b0100, rr_ptr=0 → out_valid 0001 for 4 cycles, skipped pulse, 0010 for 4 cycles, skipped pulse, 0100 then transfer; next item targets channel 3.
- Addressed mode, in_dest=1, out_ready=0 for 20 cycles then 4'b0010 → out_valid stays 4'b0010 all 20 cycles, no skipped pulse, transfer on cycle 21.
- Assert reset for one cycle while in SEND with out_valid=4'b1000 → out_valid=0, sel=0, in_ready=0 during reset; after release in_ready=1 and next round-robin item goes to channel 0.
- Toggle mode and in_dest every cycle during a held SEND → sel, out_data and out_valid unchanged until transfer.

Source files
------------

// File: rtl/dmux4_dispatcher_if.sv
// Producer/consumer bundle for the 1-to-4 demux dispatcher.
// master = producer and consumers side, slave = dispatcher side.
interface dmux4_dispatcher_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic             mode;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic             skipped;

    modport master (
        output in_valid, in_data, in_dest, mode, out_ready,
        input  in_ready, out_data, out_valid, sel, skipped
    );

    modport slave (
        input  in_valid, in_data, in_dest, mode, out_ready,
        output in_ready, out_data, out_valid, sel, skipped
    );
endinterface

// File: rtl/dmux4_dispatcher.sv
// One-item sequencer feeding a 1-to-4 demux, addressed or
// round-robin routing with stalled-channel skipping.
module dmux4_dispatcher #(
    parameter int WIDTH      = 8,
    parameter int SKIP_LIMIT = 4,
    parameter int CNT_W      = 3
) (
    input logic               clk,
    input logic               reset,
    dmux4_dispatcher_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKIP_LIMIT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             skip_q, skip_d;
    logic             in_ready;
    logic [3:0]       out_valid;

    // State register; reset drops any buffered item at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            skip_q  <= skip_d;
        end
    end

    // Capture in IDLE, deliver or skip a stalled channel in SEND.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        skip_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 4'b0000;
        unique case (state_q)
            IDLE: begin
                in_ready = !reset;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    mode_d  = bus.mode;
                    sel_d   = bus.mode ? rr_q : bus.in_dest;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 4'b0001 << sel_q;
                if (bus.out_ready[sel_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (mode_q) begin
                        rr_d = sel_q + 2'd1;
                    end
                end else if (mode_q) begin
                    if (cnt_q == CNT_MAX) begin
                        sel_d  = sel_q + 2'd1;
                        cnt_d  = '0;
                        skip_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.sel       = sel_q;
    assign bus.skipped   = skip_q;
endmodule
